// File: rtl/uart_tx.sv
// uart_tx: tick-gated UART transmitter.
// Sends a start bit, then DATA_BITS data bits LSB first, then a stop phase of SB_TICK ticks.
// Every bit period lasts OVERSAMPLE ticks of i_Tick. o_Tx comes straight from a flop.
module uart_tx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int SB_TICK    = 16
) (
   input  logic                 i_CLK,
   input  logic                 i_RESET,
   input  logic                 i_Tick,
   input  logic                 i_Tx_Start,
   input  logic [DATA_BITS-1:0] i_Data,
   output logic                 o_Tx,
   output logic                 o_Busy,
   output logic                 o_Tx_Done_Tick
);

   // Sized so one counter serves both the bit phases and the stop phase.
   localparam int CNT_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CNT_W-1:0] OS_LAST  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] SB_LAST  = CNT_W'(SB_TICK - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]           r_State;
   logic [CNT_W-1:0]     r_Cnt;
   logic [IDX_W-1:0]     r_Idx;
   logic [DATA_BITS-1:0] r_Shift;
   logic                 r_Tx;
   logic                 r_Done;

   // Frame sequencer: the start request is accepted only in IDLE; all other progress waits for i_Tick.
   // The line level for the next bit is loaded on the same edge as the state change, keeping o_Tx registered.
   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         r_State <= IDLE;
         r_Cnt   <= '0;
         r_Idx   <= '0;
         r_Shift <= '0;
         r_Tx    <= 1'b1;
         r_Done  <= 1'b0;
      end else begin
         r_Done <= 1'b0;
         case (r_State)
            IDLE: begin
               r_Tx <= 1'b1;
               if (i_Tx_Start) begin
                  r_Shift <= i_Data;
                  r_Cnt   <= '0;
                  r_State <= START;
                  r_Tx    <= 1'b0;
               end
            end
            START: begin
               if (i_Tick) begin
                  if (r_Cnt == OS_LAST) begin
                     r_Cnt   <= '0;
                     r_Idx   <= '0;
                     r_State <= DATA;
                     r_Tx    <= r_Shift[0];
                  end else begin
                     r_Cnt <= r_Cnt + CNT_W'(1);
                  end
               end
            end
            DATA: begin
               if (i_Tick) begin
                  if (r_Cnt == OS_LAST) begin
                     r_Cnt   <= '0;
                     r_Shift <= r_Shift >> 1;
                     if (r_Idx == IDX_LAST) begin
                        r_State <= STOP;
                        r_Tx    <= 1'b1;
                     end else begin
                        r_Idx <= r_Idx + IDX_W'(1);
                        r_Tx  <= r_Shift[1];
                     end
                  end else begin
                     r_Cnt <= r_Cnt + CNT_W'(1);
                  end
               end
            end
            STOP: begin
               if (i_Tick) begin
                  if (r_Cnt == SB_LAST) begin
                     r_Cnt   <= '0;
                     r_State <= IDLE;
                     r_Done  <= 1'b1;
                  end else begin
                     r_Cnt <= r_Cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               r_State <= IDLE;
               r_Tx    <= 1'b1;
            end
         endcase
      end
   end

   assign o_Tx           = r_Tx;
   assign o_Busy         = (r_State != IDLE);
   assign o_Tx_Done_Tick = r_Done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives two transmitters (1 and 2 stop bits) from shared stimulus.
// It compares every cycle against a tick-count model of the frame.
module tb_uart_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, tick, start;
   logic [7:0] data;
   logic       tx0, busy0, done0;
   logic       tx1, busy1, done1;

   uart_tx #(.DATA_BITS(8), .OVERSAMPLE(16), .SB_TICK(16)) u_dut0 (
      .i_CLK(clk), .i_RESET(rst), .i_Tick(tick), .i_Tx_Start(start), .i_Data(data),
      .o_Tx(tx0), .o_Busy(busy0), .o_Tx_Done_Tick(done0));

   uart_tx #(.DATA_BITS(8), .OVERSAMPLE(16), .SB_TICK(32)) u_dut1 (
      .i_CLK(clk), .i_RESET(rst), .i_Tick(tick), .i_Tx_Start(start), .i_Data(data),
      .o_Tx(tx1), .o_Busy(busy1), .o_Tx_Done_Tick(done1));

   int n_total = 0;
   int n_bad   = 0;

   // Reference: a frame is a count of ticks consumed since accept.
   bit         m_act  [2] = '{0, 0};
   int         m_k    [2] = '{0, 0};
   logic [7:0] m_dat  [2] = '{8'h00, 8'h00};
   bit         m_done [2] = '{0, 0};

   function automatic int frame_ticks(int i);
      return 9 * 16 + ((i == 0) ? 16 : 32);
   endfunction

   function automatic logic exp_tx(int i);
      if (!m_act[i]) return 1'b1;
      if (m_k[i] < 16) return 1'b0;
      if (m_k[i] < 9 * 16) return m_dat[i][m_k[i] / 16 - 1];
      return 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         if (rst) begin
            m_act[i] = 1'b0;
         end else if (!m_act[i]) begin
            if (start) begin
               m_act[i] = 1'b1;
               m_k[i]   = 0;
               m_dat[i] = data;
            end
         end else if (tick) begin
            m_k[i]++;
            if (m_k[i] == frame_ticks(i)) begin
               m_act[i]  = 1'b0;
               m_done[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk("tx0",   tx0,   exp_tx(0));
      chk("busy0", busy0, m_act[0]);
      chk("done0", done0, m_done[0]);
      chk("tx1",   tx1,   exp_tx(1));
      chk("busy1", busy1, m_act[1]);
      chk("done1", done1, m_done[1]);
   endtask

   // One clock: drive at negedge, model the edge, check at next negedge.
   task automatic cyc(input logic r, input logic t, input logic s, input logic [7:0] d);
      rst = r; tick = t; start = s; data = d;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      int lat0, lat1, nd0, nd1, tk1;
      rst = 1'b1; tick = 1'b0; start = 1'b0; data = 8'h00;
      @(negedge clk);
      cyc(1, 0, 0, 8'h00);
      cyc(1, 1, 1, 8'hFF);
      chk("rst_tx", tx0, 1'b1);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_done", done0, 1'b0);

      // 0xA5 with a tick every 4 clocks; i_Data scrambled after accept
      cyc(0, 0, 1, 8'hA5);
      lat0 = -1; lat1 = -1;
      for (int j = 1; j <= 720; j++) begin
         cyc(0, (j % 4) == 0, 0, 8'($urandom));
         if (done0 && lat0 < 0) lat0 = j;
         if (done1 && lat1 < 0) lat1 = j;
      end
      chk("a5_lat0", lat0, 640);
      chk("a5_lat1", lat1, 704);

      // 0xFF with i_Tick held high; stop phase differs between the two
      cyc(0, 1, 1, 8'hFF);
      lat0 = -1; lat1 = -1; tk1 = 0;
      for (int j = 1; j <= 200; j++) begin
         cyc(0, 1, 0, 8'h00);
         if (lat1 < 0) tk1++;
         if (done0 && lat0 < 0) lat0 = j;
         if (done1 && lat1 < 0) lat1 = j;
      end
      chk("ff_ticks0", lat0, 160);
      chk("ff_ticks1", tk1, 176);

      // start pulses during a frame are ignored
      cyc(0, 1, 1, 8'h3C);
      nd0 = 0; nd1 = 0;
      for (int j = 1; j <= 200; j++) begin
         cyc(0, 1, (j == 20) || (j == 75) || (j == 150), 8'($urandom));
         nd0 += int'(done0);
         nd1 += int'(done1);
      end
      chk("ign_done0", nd0, 1);
      chk("ign_done1", nd1, 1);
      chk("ign_idle0", busy0, 1'b0);

      // start held from the done cycle: back-to-back frame
      cyc(0, 1, 1, 8'h55);
      nd0 = 0; lat0 = -1;
      for (int j = 1; j <= 400; j++) begin
         cyc(0, 1, (j >= 161) && (j <= 165), 8'h81);
         nd0 += int'(done0);
         if (done0 && lat0 < 0) lat0 = j;
         if (j == 161) begin
            chk("b2b_busy", busy0, 1'b1);
            chk("b2b_tx", tx0, 1'b0);
         end
      end
      chk("b2b_lat", lat0, 160);
      chk("b2b_done", nd0, 2);

      // tick stall in the middle of data bit 1 of 0xC3
      for (int j = 0; j < 40; j++) cyc(0, 1, 0, 8'h00);
      cyc(0, 1, 1, 8'hC3);
      for (int j = 1; j <= 40; j++) cyc(0, 1, 0, 8'h00);
      for (int j = 1; j <= 200; j++) cyc(0, 0, j == 100, 8'h00);
      chk("frz_tx", tx0, 1'b1);
      chk("frz_busy", busy0, 1'b1);
      nd0 = 0;
      for (int j = 1; j <= 200; j++) begin
         cyc(0, 1, 0, 8'h00);
         nd0 += int'(done0);
      end
      chk("frz_done", nd0, 1);

      // reset for 2 clocks mid-frame with ticks pulsing
      cyc(0, 1, 1, 8'h0F);
      for (int j = 1; j <= 50; j++) cyc(0, j % 2, 0, 8'h00);
      cyc(1, 1, 0, 8'h00);
      cyc(1, 0, 0, 8'h00);
      chk("mrst_tx", tx0, 1'b1);
      chk("mrst_busy", busy0, 1'b0);
      nd0 = 0;
      for (int j = 1; j <= 40; j++) begin
         cyc(0, j % 2, 0, 8'h00);
         nd0 += int'(done0) + int'(done1) + int'(!tx0) + int'(!tx1);
      end
      chk("mrst_quiet", nd0, 0);

      // random traffic
      for (int j = 0; j < 3000; j++) begin
         cyc($urandom_range(0, 299) == 0,
             (j < 1500) ? ($urandom_range(0, 1) == 1) : 1'b1,
             $urandom_range(0, 7) == 0,
             8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
